decode_stage: RTL

- RV32I instruction decode pipeline stage between fetch and execute.
- Holds one instruction and drives the register-file read addresses from it.
- Extracts rd, function bits and the sign-extended immediate, and hands the result to execute through a valid/ready handshake.
- Optional scoreboard stalls on read-after-write hazards against in-flight writes.

---
 rtl/rv32i_pkg.sv | 32 +++
 rtl/imm_gen.sv | 33 +++
 rtl/decode_stage.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/rv32i_pkg.sv
// RV32I decode constants: base opcodes, immediate format selector, canonical NOP.
// Latency: none (declarations only).
// Backpressure: not applicable.
//
// Shared by decode_stage and imm_gen.
package rv32i_pkg;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_fmt_e;

    // addi x0,x0,0
    localparam logic [31:0] NOP = 32'h0000_0013;

endpackage

// File: rtl/imm_gen.sv
// RV32I immediate extraction and sign extension for all base formats.
// Latency: purely combinational.
// Backpressure: none; output follows the inputs.
//
// Ports:
//   instr  in  32  instruction word
//   fmt    in      immediate format selector (IMM_NONE yields zero)
//   imm    out 32  sign-extended immediate
module imm_gen
    import rv32i_pkg::*;
(
    input  logic [31:0] instr,
    input  imm_fmt_e    fmt,
    output logic [31:0] imm
);

    // The opcode field carries no immediate bits.
    logic unused_opc;
    assign unused_opc = ^instr[6:0];

    always_comb begin
        imm = 32'd0;
        case (fmt)
            IMM_I: imm = {{20{instr[31]}}, instr[31:20]};
            IMM_S: imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B: imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U: imm = {instr[31:12], 12'd0};
            IMM_J: imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm = 32'd0;
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode pipeline stage: holds one instruction, drives RF read addresses, decodes fields.
// Latency: instruction accepted at edge N is presented on id_*/rf_raddr* during cycle N+1.
// Backpressure: valid/ready both sides; accept and issue in one cycle gives 1 instr/cycle.
//
// Optional macro DECODE_SCOREBOARD_EN: adds a busy-register scoreboard that holds
// id_valid low while a source register has an in-flight write.
// Ports: clk, rst (async, active high); fetch side if_valid/if_ready/if_instr/if_pc;
// flush; rf_raddr1/2; execute side id_valid/id_ready and decoded id_* fields;
// writeback wb_we/wb_waddr (scoreboard only).
module decode_stage
    import rv32i_pkg::*;
#(
    parameter int          XLEN      = 32,
    parameter logic [31:0] NOP_INSTR = NOP
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_valid,
    output logic            if_ready,
    input  logic [31:0]     if_instr,
    input  logic [XLEN-1:0] if_pc,
    input  logic            flush,
    output logic [4:0]      rf_raddr1,
    output logic [4:0]      rf_raddr2,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [XLEN-1:0] id_pc,
    output logic [6:0]      id_opcode,
    output logic [2:0]      id_funct3,
    output logic            id_funct7b5,
    output logic [4:0]      id_rd,
    output logic            id_we,
    output logic [31:0]     id_imm,
    output logic            id_illegal,
    input  logic            wb_we,
    input  logic [4:0]      wb_waddr
);

    logic            valid_q;
    logic [31:0]     instr_q;
    logic [XLEN-1:0] pc_q;
    logic            stall;
    logic            accept;
    logic            issue;

    imm_fmt_e fmt;
    logic     use_rs1;
    logic     use_rs2;
    logic     writes_rd;
    logic     legal;

    // Every listed opcode ends in 2'b11, so matching the full 7 bits also
    // rejects compressed encodings.
    always_comb begin
        fmt       = IMM_NONE;
        use_rs1   = 1'b0;
        use_rs2   = 1'b0;
        writes_rd = 1'b0;
        legal     = 1'b1;
        case (instr_q[6:0])
            OPC_LUI, OPC_AUIPC: begin fmt = IMM_U; writes_rd = 1'b1; end
            OPC_JAL:            begin fmt = IMM_J; writes_rd = 1'b1; end
            OPC_JALR:           begin fmt = IMM_I; writes_rd = 1'b1; use_rs1 = 1'b1; end
            OPC_BRANCH:         begin fmt = IMM_B; use_rs1 = 1'b1; use_rs2 = 1'b1; end
            OPC_LOAD:           begin fmt = IMM_I; writes_rd = 1'b1; use_rs1 = 1'b1; end
            OPC_STORE:          begin fmt = IMM_S; use_rs1 = 1'b1; use_rs2 = 1'b1; end
            OPC_OP_IMM:         begin fmt = IMM_I; writes_rd = 1'b1; use_rs1 = 1'b1; end
            OPC_OP:             begin writes_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; end
            OPC_MISC_MEM:       ;
            OPC_SYSTEM:         fmt = IMM_I;
            default:            legal = 1'b0;
        endcase
    end

    imm_gen u_imm_gen (
        .instr (instr_q),
        .fmt   (fmt),
        .imm   (id_imm)
    );

    assign rf_raddr1   = use_rs1 ? instr_q[19:15] : 5'd0;
    assign rf_raddr2   = use_rs2 ? instr_q[24:20] : 5'd0;
    assign id_pc       = pc_q;
    assign id_opcode   = instr_q[6:0];
    assign id_funct3   = instr_q[14:12];
    assign id_funct7b5 = instr_q[30];
    assign id_rd       = instr_q[11:7];
    assign id_illegal  = !legal;
    assign id_we       = legal && writes_rd && (instr_q[11:7] != 5'd0);

    assign id_valid = valid_q && !stall;
    assign if_ready = !flush && (!valid_q || (id_ready && !stall));
    assign accept   = if_valid && if_ready;
    // A flushed instruction is squashed, so it never counts as issued.
    assign issue    = id_valid && id_ready && !flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            instr_q <= NOP_INSTR;
            pc_q    <= '0;
        end else if (flush) begin
            valid_q <= 1'b0;
            instr_q <= NOP_INSTR;
        end else if (accept) begin
            valid_q <= 1'b1;
            instr_q <= if_instr;
            pc_q    <= if_pc;
        end else if (issue) begin
            valid_q <= 1'b0;
        end
    end

`ifdef DECODE_SCOREBOARD_EN
    logic [31:0] busy_q;
    logic [31:0] busy_d;

    // Clear first so a same-cycle set on the same register wins.
    always_comb begin
        busy_d = busy_q;
        if (wb_we)
            busy_d[wb_waddr] = 1'b0;
        if (issue && id_we)
            busy_d[id_rd] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            busy_q <= '0;
        else
            busy_q <= busy_d;
    end

    assign stall = valid_q && (busy_q[rf_raddr1] || busy_q[rf_raddr2]);
`else
    logic unused_wb;
    assign unused_wb = wb_we ^ (^wb_waddr);
    assign stall     = 1'b0;
`endif

endmodule
